mem_load_unit: RTL and testbench
================================

Name: mem_load_unit

Overview:
- Sequences one memory read on behalf of the multicycle control unit and returns write-back-ready data for the register-bank WriteData path.
- Supports word, halfword and byte loads from little-endian, word-aligned synchronous memory, with sign or zero extension.
- Start/done handshake on the control side; single-beat read strobe on the memory side.

Parameters:
- MEM_LATENCY, 1, cycles from the mem_rd pulse to valid mem_data_in (legal range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a load; sampled only in IDLE.
- addr  input  32  byte address of the load.
- size  input  2  00 = word, 01 = halfword, 10 = byte, 11 = treated as word.
- sign_ext  input  1  1 = sign-extend, 0 = zero-extend (ignored for word).
- mem_addr  output  32  word-aligned address to memory.
- mem_rd  output  1  one-cycle read strobe.
- mem_data_in  input  32  read data from memory.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse; load_data is valid.
- load_data  output  32  extended result; held until the next capture.

Behaviour:
- Reset (asynchronous, while reset = 0):
  - FSM goes to IDLE.
  - mem_addr = 0, mem_rd = 0, busy = 0, done = 0, load_data = 0, wait counter = 0.
- FSM states: IDLE -> REQ -> WAIT -> DONE -> IDLE.
- IDLE:
  - If start = 1 at an edge: latch addr[1:0], size and sign_ext; set mem_addr = {addr[31:2], 2'b00}; go to REQ.
  - Otherwise remain in IDLE.
- REQ:
  - mem_rd = 1 for exactly this cycle.
  - Counter loads MEM_LATENCY-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter equals 0, capture mem_data_in, extract, extend into load_data, and go to DONE.
- DONE:
  - done = 1 for one cycle; go to IDLE.
- Latency: start sampled at edge T gives mem_rd high in cycle T+1 and done high in cycle T+2+MEM_LATENCY. For MEM_LATENCY = 1, done is high 3 cycles after start.
- Back-to-back: a start asserted during the DONE cycle is ignored. A new start is accepted only in IDLE, so the minimum issue interval is MEM_LATENCY+3 cycles.
- start asserted while busy = 1 is ignored; the latched operands are not disturbed.
- Extraction, with off = latched addr[1:0]:
  - Word: load_data = mem_data_in; off ignored (no checking unless the optional feature is enabled).
  - Halfword: off[1] = 0 selects bits [15:0], off[1] = 1 selects [31:16]; off[0] ignored. Extend bit 15 of the selected half if sign_ext = 1, else zero-fill.
  - Byte: off selects bits [8*off+7 : 8*off]; extend from bit 7 of the selected byte.
- mem_addr holds its value from REQ until the next accepted start.
- Reset mid-operation: immediate return to IDLE, no done pulse, load_data cleared to 0.

Optional Feature:
- Macro: LOAD_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - An accepted start with a word access and addr[1:0] != 0, or a halfword access and addr[0] = 1, goes IDLE -> DONE directly.
  - No mem_rd is issued; load_data is unchanged; misalign and done pulse together for one cycle.
- Undefined:
  - No misalign port.
  - Misaligned addresses are silently truncated as described under Extraction.

Test Plan:
- MEM_LATENCY = 1, addr = 0x0000_0010, size = 00, memory returns 0xDEAD_BEEF -> mem_rd pulses in cycle T+1 with mem_addr = 0x10; done in cycle T+3; load_data = 0xDEAD_BEEF.
- addr = 0x0000_0013, size = 10, sign_ext = 1, memory word 0x80FF_0000 -> load_data = 0xFFFF_FF80. Repeat with sign_ext = 0 -> 0x0000_0080.
- addr = 0x0000_0006, size = 01, sign_ext = 1, memory word 0x9ABC_1234 -> load_data = 0xFFFF_9ABC. Repeat with addr = 0x4 -> 0x0000_1234.
- MEM_LATENCY = 4; start held high continuously -> loads issue every 7 cycles; exactly one mem_rd per load; done spacing is 7 cycles.
- reset driven low during WAIT -> all outputs 0 immediately; no done; the next start completes normally.
- LOAD_ALIGN_CHECK_EN defined, word load at addr = 0x2 -> misalign and done high at T+1; mem_rd never asserted; load_data retains its previous value.

Source files
------------

// File: rtl/mem_load_unit.sv
// Load sequencer: issues one word-aligned memory read and returns extended load data.
// Optional LOAD_ALIGN_CHECK_EN adds a misalign output and skips the read for misaligned accesses.
module mem_load_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_data_in,
  output logic        busy,
  output logic        done,
`ifdef LOAD_ALIGN_CHECK_EN
  output logic [31:0] load_data,
  output logic        misalign
`else
  output logic [31:0] load_data
`endif
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         off_q;
  logic [1:0]         size_q;
  logic               sign_q;
  logic [31:0]        ext_c;

  // Lane select and extension of the returned word using the latched operands.
  always_comb begin
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    half_sel = off_q[1] ? mem_data_in[31:16] : mem_data_in[15:0];
    case (off_q)
      2'd0:    byte_sel = mem_data_in[7:0];
      2'd1:    byte_sel = mem_data_in[15:8];
      2'd2:    byte_sel = mem_data_in[23:16];
      default: byte_sel = mem_data_in[31:24];
    endcase
    case (size_q)
      2'b01:   ext_c = {{16{sign_q & half_sel[15]}}, half_sel};
      2'b10:   ext_c = {{24{sign_q & byte_sel[7]}}, byte_sel};
      default: ext_c = mem_data_in;
    endcase
  end

`ifdef LOAD_ALIGN_CHECK_EN
  logic mis_c;
  always_comb begin
    mis_c = 1'b0;
    case (size)
      2'b01:   mis_c = addr[0];
      2'b10:   mis_c = 1'b0;
      default: mis_c = (addr[1:0] != 2'b00);
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      sign_q    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_rd    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      load_data <= 32'h0;
`ifdef LOAD_ALIGN_CHECK_EN
      misalign  <= 1'b0;
`endif
    end else begin
      mem_rd <= 1'b0;
      done   <= 1'b0;
`ifdef LOAD_ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            off_q    <= addr[1:0];
            size_q   <= size;
            sign_q   <= sign_ext;
            mem_addr <= {addr[31:2], 2'b00};
            busy     <= 1'b1;
`ifdef LOAD_ALIGN_CHECK_EN
            if (mis_c) begin
              state    <= S_DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state  <= S_REQ;
              mem_rd <= 1'b1;
            end
`else
            state  <= S_REQ;
            mem_rd <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          cnt   <= CNT_W'(MEM_LATENCY - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            load_data <= ext_c;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit with latency-1 and latency-4 instances and a small memory model.
module tb_mem_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start4;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sign_ext;

  logic [31:0] mem_addr1, data1, ld1, word1;
  logic        mem_rd1, busy1, done1;
  logic [31:0] mem_addr4, data4, ld4, word4;
  logic        mem_rd4, busy4, done4;
`ifdef LOAD_ALIGN_CHECK_EN
  logic        misalign1, misalign4;
`endif

  int checks, failures;
  int rd_cyc[8];
  int dn_cyc[8];
  int n_rd, n_dn, done_seen;

  always #5 clk = ~clk;

  mem_load_unit #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .size(size), .sign_ext(sign_ext),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_data_in(data1), .busy(busy1), .done(done1),
`ifdef LOAD_ALIGN_CHECK_EN
    .load_data(ld1), .misalign(misalign1)
`else
    .load_data(ld1)
`endif
  );

  mem_load_unit #(.MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .addr(addr), .size(size), .sign_ext(sign_ext),
    .mem_addr(mem_addr4), .mem_rd(mem_rd4), .mem_data_in(data4), .busy(busy4), .done(done4),
`ifdef LOAD_ALIGN_CHECK_EN
    .load_data(ld4), .misalign(misalign4)
`else
    .load_data(ld4)
`endif
  );

  // Synchronous memory: data is valid exactly MEM_LATENCY cycles after the read strobe.
  logic       pipe1;
  logic [3:0] pipe4;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe1 <= 1'b0;
      pipe4 <= 4'b0;
    end else begin
      pipe1 <= mem_rd1;
      pipe4 <= {pipe4[2:0], mem_rd4};
    end
  end
  assign data1 = pipe1    ? word1 : 32'h0BAD_F00D;
  assign data4 = pipe4[3] ? word4 : 32'h0BAD_F00D;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load on the latency-1 unit; operands are scrambled and start held while busy.
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic se,
                          input logic [31:0] w, input logic [31:0] exp, input string tag);
    @(negedge clk);
    addr = a; size = sz; sign_ext = se; word1 = w; start = 1'b1;
    @(posedge clk); #1;
    check({tag, ".rd"}, 32'(mem_rd1), 32'h1);
    check({tag, ".maddr"}, mem_addr1, {a[31:2], 2'b00});
    check({tag, ".busy"}, 32'(busy1), 32'h1);
    addr = ~a; size = ~sz; sign_ext = ~se;
    @(posedge clk); #1;
    check({tag, ".rd_off"}, 32'(mem_rd1), 32'h0);
    check({tag, ".early_done"}, 32'(done1), 32'h0);
    @(posedge clk); #1;
    check({tag, ".done"}, 32'(done1), 32'h1);
    check({tag, ".data"}, ld1, exp);
    @(posedge clk); #1;
    check({tag, ".done_off"}, 32'(done1), 32'h0);
    check({tag, ".idle"}, 32'(busy1), 32'h0);
    check({tag, ".held"}, ld1, exp);
    start = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; start = 1'b0; start4 = 1'b0;
    addr = 32'h0; size = 2'b00; sign_ext = 1'b0;
    word1 = 32'h0; word4 = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.maddr", mem_addr1, 32'h0);
    check("rst.rd", 32'(mem_rd1), 32'h0);
    check("rst.busy", 32'(busy1), 32'h0);
    check("rst.done", 32'(done1), 32'h0);
    check("rst.data", ld1, 32'h0);
    check("rst.busy4", 32'(busy4), 32'h0);
    @(negedge clk); reset = 1'b1;

    run_load(32'h0000_0010, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "word");
    run_load(32'h0000_0013, 2'b10, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80, "byte3_s");
    run_load(32'h0000_0013, 2'b10, 1'b0, 32'h80FF_0000, 32'h0000_0080, "byte3_z");
    run_load(32'h0000_0012, 2'b10, 1'b1, 32'h80FF_0000, 32'hFFFF_FFFF, "byte2_s");
    run_load(32'h0000_0011, 2'b10, 1'b1, 32'h0000_7F00, 32'h0000_007F, "byte1_s");
    run_load(32'h0000_0006, 2'b01, 1'b1, 32'h9ABC_1234, 32'hFFFF_9ABC, "half_hi_s");
    run_load(32'h0000_0006, 2'b01, 1'b0, 32'h9ABC_1234, 32'h0000_9ABC, "half_hi_z");
    run_load(32'h0000_0004, 2'b01, 1'b1, 32'h9ABC_1234, 32'h0000_1234, "half_lo_s");
    run_load(32'h0000_0008, 2'b11, 1'b1, 32'h8357_9BDF, 32'h8357_9BDF, "size3_word");
`ifndef LOAD_ALIGN_CHECK_EN
    run_load(32'h0000_0005, 2'b01, 1'b1, 32'h0000_8765, 32'hFFFF_8765, "half_odd");
    run_load(32'h0000_0003, 2'b00, 1'b0, 32'h1234_5678, 32'h1234_5678, "word_odd");
`endif

    // Reset asserted in the WAIT cycle clears everything at once.
    @(negedge clk);
    addr = 32'h0000_0020; size = 2'b00; sign_ext = 1'b0; word1 = 32'h1111_2222; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("mid_rst.maddr", mem_addr1, 32'h0);
    check("mid_rst.rd", 32'(mem_rd1), 32'h0);
    check("mid_rst.busy", 32'(busy1), 32'h0);
    check("mid_rst.done", 32'(done1), 32'h0);
    check("mid_rst.data", ld1, 32'h0);
    @(negedge clk); reset = 1'b1;
    done_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done1) done_seen++;
    end
    check("mid_rst.no_done", 32'(done_seen), 32'h0);
    check("mid_rst.idle", 32'(busy1), 32'h0);
    run_load(32'h0000_0020, 2'b00, 1'b0, 32'h1111_2222, 32'h1111_2222, "after_rst");

    // Latency 4 with start held high: one read per load, 7-cycle issue spacing.
    n_rd = 0; n_dn = 0;
    @(negedge clk);
    addr = 32'h0000_0040; size = 2'b00; sign_ext = 1'b0; word4 = 32'h2468_ACE0; start4 = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(posedge clk); #1;
      if (mem_rd4) begin
        if (n_rd < 8) rd_cyc[n_rd] = cyc;
        n_rd++;
      end
      if (done4) begin
        if (n_dn < 8) dn_cyc[n_dn] = cyc;
        n_dn++;
        check("l4.data", ld4, 32'h2468_ACE0);
      end
    end
    start4 = 1'b0;
    check("l4.n_rd", 32'(n_rd), 32'd4);
    check("l4.n_done", 32'(n_dn), 32'd3);
    check("l4.first_rd", 32'(rd_cyc[0]), 32'd1);
    check("l4.first_done", 32'(dn_cyc[0]), 32'd6);
    check("l4.rd_gap1", 32'(rd_cyc[1] - rd_cyc[0]), 32'd7);
    check("l4.rd_gap2", 32'(rd_cyc[2] - rd_cyc[1]), 32'd7);
    check("l4.done_gap", 32'(dn_cyc[1] - dn_cyc[0]), 32'd7);
    check("l4.maddr", mem_addr4, 32'h0000_0040);
    repeat (8) @(posedge clk);

`ifdef LOAD_ALIGN_CHECK_EN
    // Misaligned word: straight to DONE with misalign, no read, data untouched.
    @(negedge clk);
    addr = 32'h0000_0002; size = 2'b00; sign_ext = 1'b0; word1 = 32'hCAFE_CAFE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mis.misalign", 32'(misalign1), 32'h1);
    check("mis.done", 32'(done1), 32'h1);
    check("mis.rd", 32'(mem_rd1), 32'h0);
    check("mis.data", ld1, 32'h1111_2222);
    @(posedge clk); #1;
    check("mis.misalign_off", 32'(misalign1), 32'h0);
    check("mis.done_off", 32'(done1), 32'h0);
    check("mis.rd_off", 32'(mem_rd1), 32'h0);
    check("mis.idle", 32'(busy1), 32'h0);
    check("mis.data_held", ld1, 32'h1111_2222);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
